// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter.
package ram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int unsigned ADDR_W = 32;

  // Index width for n requesters; never below 1 so index vectors stay legal.
  function automatic int unsigned calc_idw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side request/response bundle for the RAM arbiter.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DWIDTH = 32
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DWIDTH-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DWIDTH-1:0]      rsp_rdata;

  // Arbiter side
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

  // Requester side
  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-mask priority picker: lowest requester at or above ptr wins, wrapping to
// the lowest overall. With ptr tied to zero it is a plain fixed-priority encoder.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] sel;
  logic            found;

  // Mask off requesters below the pointer; fall back to the full set if none remain.
  always_comb begin
    mask  = '0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      mask[i] = (i >= int'(ptr));
    end
    sel = (|(req & mask)) ? (req & mask) : req;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (sel[i] && !found) begin
        grant[i] = 1'b1;
        idx      = IDW'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM among NREQ requesters, one access per cycle.
// Define ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int unsigned IDW = calc_idw(NREQ);

  state_e            state_q, state_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    win_idx;
  logic [IDW-1:0]    ptr;
  logic              accept;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

`ifdef ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Pointer moves just past the winner on every accept.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  // Grant already implies valid, so ready never asserts without a request.
  assign bus.req_ready = rst ? '0 : grant;
  assign accept        = (|grant) && !rst;

  // Request mux for the winning requester.
  always_comb begin
    sel_wr    = bus.req_wr[win_idx];
    sel_addr  = bus.req_addr[ADDR_W*win_idx +: ADDR_W];
    sel_wdata = bus.req_wdata[DWIDTH*win_idx +: DWIDTH];
  end

  // FSM next state: accept in either state launches an access next cycle.
  always_comb begin
    state_d     = IDLE;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    id_d        = id_q;
    if (accept) begin
      state_d     = ACCESS;
      mem_wr_d    = sel_wr;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      id_d        = win_idx;
    end
  end

  // Response: pulse the issuer's bit after the access cycle; reads capture RAM data.
  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == ACCESS) begin
      rsp_valid_d[id_q] = 1'b1;
      if (!mem_wr_q) rsp_rdata_d = mem_rdata;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      id_q        <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Gate enables with rst so an access in flight when reset hits never writes the RAM.
  assign mem_en        = (state_q == ACCESS) && !rst;
  assign mem_wr        = mem_wr_q && !rst;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
